ifetch_unit: RTL

Instruction fetch stage for the DLX-style core; produces the 32-bit instruction word that the control decoder consumes. It also consumes the decoder's BRANCH/JUMP outputs to steer the PC. Owns the PC register, the instruction-memory request/response handshake, a response timeout counter and the issue handshake toward decode.

---
 rtl/ifetch_pkg.sv | 30 +++
 rtl/ifetch_next_pc.sv | 41 ++++
 rtl/ifetch_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM encoding,
// instruction field bounds and the DLX control-flow opcodes.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  localparam logic [0:31] NOP = 32'h0000_0000;

  // Bit 0 is the MSB on every [0:31] word
  localparam int JOFF_LO = 6;
  localparam int JOFF_HI = 31;
  localparam int IMM_LO  = 16;
  localparam int IMM_HI  = 31;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;

  function automatic logic [0:31] word_align(input logic [0:31] a);
    return {a[0:29], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Combinational next-PC selection for the fetch stage: jump-register, PC-relative
// jump, taken branch or sequential, with the result forced to word alignment.
module ifetch_next_pc
  import ifetch_pkg::*;
(
  input  logic [0:31]      pc_i,
  input  logic [JOFF_LO:31] instr_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             br_taken_i,
  input  logic             jreg_i,
  input  logic [0:31]      rs_value_i,
  output logic [0:31]      next_pc_o,
  output logic             redirect_o
);

  logic [0:31] pc_seq;
  logic [0:31] joff;
  logic [0:31] ioff;
  logic [0:31] target;

  assign pc_seq = pc_i + 32'd4;
  assign joff   = {{JOFF_LO{instr_i[JOFF_LO]}}, instr_i[JOFF_LO:JOFF_HI]};
  assign ioff   = {{IMM_LO{instr_i[IMM_LO]}}, instr_i[IMM_LO:IMM_HI]};

  // JUMP is tested first so it wins when the decoder raises both
  always_comb begin
    target = pc_seq;
    if (jump_i && jreg_i) begin
      target = rs_value_i;
    end else if (jump_i) begin
      target = pc_seq + joff;
    end else if (branch_i && br_taken_i) begin
      target = pc_seq + ioff;
    end
  end

  assign next_pc_o  = word_align(target);
  assign redirect_o = jump_i | (branch_i & br_taken_i);

endmodule

// File: rtl/ifetch_unit.sv
// DLX fetch stage: PC register, imem request/response handshake with timeout,
// and issue toward decode. Define IFETCH_DELAY_SLOT_EN for one branch delay slot.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_valid,
  input  logic [0:31] imem_rdata,
  output logic [0:31] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        br_taken,
  input  logic        jreg,
  input  logic [0:31] rs_value,
  output logic [0:31] pc_plus4,
  output logic        fetch_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e      state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        req_q, req_d;
  logic [0:31] addr_q, addr_d;
  logic [0:31] instr_q, instr_d;
  logic        ivld_q, ivld_d;
  logic [0:31] pc4_q, pc4_d;
  logic        err_q, err_d;
  logic [0:31] pc_seq;
  logic [0:31] next_pc;
  logic        redirect;
  logic        timeout;
`ifdef IFETCH_DELAY_SLOT_EN
  logic        slot_q, slot_d;
  logic [0:31] pend_q, pend_d;
`endif

  assign pc_seq  = pc_q + 32'd4;
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_inc == CW'(MAX_WAIT));

  ifetch_next_pc u_next_pc (
    .pc_i       (pc_q),
    .instr_i    (instr_q[JOFF_LO:31]),
    .branch_i   (BRANCH),
    .jump_i     (JUMP),
    .br_taken_i (br_taken),
    .jreg_i     (jreg),
    .rs_value_i (rs_value),
    .next_pc_o  (next_pc),
    .redirect_o (redirect)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_REQ;
    else       state_q <= state_d;
  end

  // REQ is left only once the strobe has actually been presented, so the
  // first REQ after reset spends one cycle raising it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:   if (req_q) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_valid)   state_d = ST_ISSUE;
        else if (timeout) state_d = ST_REQ;
      end
      ST_ISSUE: if (!stall) state_d = ST_REQ;
      default:  state_d = ST_REQ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ivld_d  = ivld_q;
    pc4_d   = pc4_q;
    err_d   = err_q;
`ifdef IFETCH_DELAY_SLOT_EN
    slot_d  = slot_q;
    pend_d  = pend_q;
`endif
    case (state_q)
      ST_REQ: cnt_d = '0;
      ST_WAIT: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          ivld_d  = 1'b1;
          pc4_d   = pc_seq;
        end else begin
          cnt_d = cnt_inc;
          if (timeout) err_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          ivld_d = 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
          // Control flow of the slot instruction itself is ignored
          if (slot_q) begin
            pc_d   = pend_q;
            slot_d = 1'b0;
          end else if (redirect) begin
            pend_d = next_pc;
            slot_d = 1'b1;
            pc_d   = word_align(pc_seq);
          end else begin
            pc_d   = next_pc;
          end
`else
          pc_d = redirect ? next_pc : word_align(pc_seq);
`endif
        end
      end
      default: ;
    endcase
    req_d  = (state_d == ST_REQ);
    addr_d = req_d ? pc_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= NOP;
      ivld_q  <= 1'b0;
      pc4_q   <= '0;
      err_q   <= 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
      slot_q  <= 1'b0;
      pend_q  <= '0;
`endif
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ivld_q  <= ivld_d;
      pc4_q   <= pc4_d;
      err_q   <= err_d;
`ifdef IFETCH_DELAY_SLOT_EN
      slot_q  <= slot_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = ivld_q;
  assign pc_plus4    = pc4_q;
  assign fetch_err   = err_q;

endmodule
